// File: rtl/ex_mult_div_unit.sv
// EX-stage multiply/divide unit holding architectural HI/LO.
// Results are computed at accept and committed after a fixed busy period.
module ex_mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_Start,
  input  logic [2:0]  e_MDOp,
  input  logic [31:0] e_A,
  input  logic [31:0] e_B,
  output logic        e_Busy,
  output logic [31:0] e_HI,
  output logic [31:0] e_LO
);

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        res_wr_q, res_wr_d;
  logic        busy_q, busy_d;

  logic [63:0] prod_u, prod_s;
  logic [31:0] dvs_u, abs_a, abs_b, dvs_s;
  logic [31:0] q_u, r_u, q_m, r_m, q_s, r_s;
  logic        b_zero, is_arith, is_mult, accept;

  always_comb begin
    prod_u = {32'b0, e_A} * {32'b0, e_B};
    prod_s = {{32{e_A[31]}}, e_A} * {{32{e_B[31]}}, e_B};
    b_zero = (e_B == 32'd0);
    // Divisor forced to 1 on zero; that result is never committed
    dvs_u  = b_zero ? 32'd1 : e_B;
    q_u    = e_A / dvs_u;
    r_u    = e_A % dvs_u;
    // Signed divide via magnitudes: quotient truncates toward zero,
    // remainder follows the dividend; 0x80000000/-1 wraps naturally.
    abs_a  = e_A[31] ? -e_A : e_A;
    abs_b  = e_B[31] ? -e_B : e_B;
    dvs_s  = b_zero ? 32'd1 : abs_b;
    q_m    = abs_a / dvs_s;
    r_m    = abs_a % dvs_s;
    q_s    = (e_A[31] ^ e_B[31]) ? -q_m : q_m;
    r_s    = e_A[31] ? -r_m : r_m;
    is_arith = (e_MDOp >= MD_MULT) && (e_MDOp <= MD_DIVU);
    is_mult  = (e_MDOp == MD_MULT) || (e_MDOp == MD_MULTU);
    accept   = (state_q == S_IDLE) && e_Start && is_arith;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    busy_d   = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_BUSY;
          busy_d   = 1'b1;
          cnt_d    = is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          res_wr_d = is_mult || !b_zero;
          unique case (e_MDOp)
            MD_MULT:  {res_hi_d, res_lo_d} = prod_s;
            MD_MULTU: {res_hi_d, res_lo_d} = prod_u;
            MD_DIV:   {res_hi_d, res_lo_d} = {r_s, q_s};
            default:  {res_hi_d, res_lo_d} = {r_u, q_u};
          endcase
        end else if (e_MDOp == MD_MTHI) begin
          hi_d = e_A;
        end else if (e_MDOp == MD_MTLO) begin
          lo_d = e_A;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d    = 4'd0;
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          res_wr_d = 1'b0;
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
      busy_q   <= busy_d;
    end
  end

  assign e_Busy = busy_q;
  assign e_HI   = hi_q;
  assign e_LO   = lo_q;

endmodule

// File: tb/tb_ex_mult_div_unit.sv
// Directed bench for ex_mult_div_unit.
// Expected values are hand-computed constants.
module tb_ex_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_Start;
  logic [2:0]  e_MDOp;
  logic [31:0] e_A, e_B;
  logic        e_Busy;
  logic [31:0] e_HI, e_LO;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .e_Start(e_Start), .e_MDOp(e_MDOp),
    .e_A(e_A), .e_B(e_B), .e_Busy(e_Busy), .e_HI(e_HI), .e_LO(e_LO)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an op, check busy for n cycles with HI/LO held, then check idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    logic [31:0] hi0, lo0;
    hi0 = e_HI;
    lo0 = e_LO;
    e_Start = 1'b1; e_MDOp = op; e_A = a; e_B = b;
    step();
    e_Start = 1'b0; e_MDOp = 3'd0; e_A = 32'hDEAD_BEEF; e_B = 32'h3;
    for (int i = 0; i < n; i++) begin
      check($sformatf("busy_c%0d", i), {31'b0, e_Busy}, 32'd1);
      check($sformatf("hold_hi_c%0d", i), e_HI, hi0);
      check($sformatf("hold_lo_c%0d", i), e_LO, lo0);
      step();
    end
    check("busy_done", {31'b0, e_Busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; e_Start = 1'b0; e_MDOp = 3'd0; e_A = '0; e_B = '0;
    step(); step();
    check("rst_busy", {31'b0, e_Busy}, 32'd0);
    check("rst_hi", e_HI, 32'd0);
    check("rst_lo", e_LO, 32'd0);
    reset = 1'b0;

    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 5);
    check("mult_hi", e_HI, 32'hFFFF_FFFF);
    check("mult_lo", e_LO, 32'hFFFF_FFF1);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check("divovf_hi", e_HI, 32'h0000_0000);
    check("divovf_lo", e_LO, 32'h8000_0000);

    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5);
    check("multu_hi", e_HI, 32'h0000_0001);
    check("multu_lo", e_LO, 32'hFFFF_FFFE);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 10);
    check("div_hi", e_HI, 32'hFFFF_FFFF);
    check("div_lo", e_LO, 32'hFFFF_FFFD);

    run_op(3'd4, 32'd7, 32'd0, 10);
    check("divz_hi", e_HI, 32'hFFFF_FFFF);
    check("divz_lo", e_LO, 32'hFFFF_FFFD);

    run_op(3'd4, 32'd100, 32'd7, 10);
    check("divu_hi", e_HI, 32'd2);
    check("divu_lo", e_LO, 32'd14);

    // mult 3*4 with a divu start and an mthi landing during busy
    e_Start = 1'b1; e_MDOp = 3'd1; e_A = 32'd3; e_B = 32'd4;
    step();
    e_Start = 1'b0; e_MDOp = 3'd0;
    check("ign_busy1", {31'b0, e_Busy}, 32'd1);
    step();
    e_Start = 1'b1; e_MDOp = 3'd4; e_A = 32'd9; e_B = 32'd2;
    check("ign_busy2", {31'b0, e_Busy}, 32'd1);
    step();
    e_Start = 1'b0; e_MDOp = 3'd5; e_A = 32'h0000_AAAA;
    check("ign_busy3", {31'b0, e_Busy}, 32'd1);
    step();
    e_MDOp = 3'd0;
    check("ign_busy4", {31'b0, e_Busy}, 32'd1);
    check("ign_hi_held", e_HI, 32'd2);
    step();
    check("ign_busy5", {31'b0, e_Busy}, 32'd1);
    step();
    check("ign_done", {31'b0, e_Busy}, 32'd0);
    check("ign_hi", e_HI, 32'd0);
    check("ign_lo", e_LO, 32'd12);
    step(); step();
    check("ign_norestart", {31'b0, e_Busy}, 32'd0);
    check("ign_lo_kept", e_LO, 32'd12);

    // mtlo then mthi while idle
    e_MDOp = 3'd6; e_A = 32'h0000_0055;
    step();
    check("mtlo_busy", {31'b0, e_Busy}, 32'd0);
    check("mtlo_lo", e_LO, 32'h0000_0055);
    check("mtlo_hi", e_HI, 32'd0);
    e_MDOp = 3'd5; e_A = 32'h0000_1234;
    step();
    e_MDOp = 3'd0;
    check("mthi_busy", {31'b0, e_Busy}, 32'd0);
    check("mthi_hi", e_HI, 32'h0000_1234);
    check("mthi_lo", e_LO, 32'h0000_0055);
    step();
    check("mthi_busy2", {31'b0, e_Busy}, 32'd0);

    // start with op 7 must not start anything
    e_Start = 1'b1; e_MDOp = 3'd7;
    step();
    e_Start = 1'b0; e_MDOp = 3'd0;
    check("op7_busy", {31'b0, e_Busy}, 32'd0);

    // div 100/7 aborted by reset in busy cycle 3
    e_Start = 1'b1; e_MDOp = 3'd3; e_A = 32'd100; e_B = 32'd7;
    step();
    e_Start = 1'b0; e_MDOp = 3'd0;
    step();
    step();
    check("abort_busy_pre", {31'b0, e_Busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", {31'b0, e_Busy}, 32'd0);
    check("abort_hi", e_HI, 32'd0);
    check("abort_lo", e_LO, 32'd0);
    for (int i = 0; i < 12; i++) step();
    check("abort_busy_late", {31'b0, e_Busy}, 32'd0);
    check("abort_hi_late", e_HI, 32'd0);
    check("abort_lo_late", e_LO, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
